// File: rtl/adc_fft_pkg.sv
// Shared types and constants for the ADC-to-FFT framer.
// Holds the FSM encoding, the tuser bit positions and a clog2 helper usable in parameters.
package adc_fft_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int TUSER_SOF = 0;
  localparam int TUSER_PAD = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PAD  = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/adc_fft_sync_fifo.sv
// Single-clock elastic FIFO with extra-MSB pointers and a synchronous flush.
// A write while full is accepted when a read happens in the same cycle.
module adc_fft_sync_fifo
  import adc_fft_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic             sys_clk,
  input  logic             sys_rstn,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             wr_ok;
  logic             rd_ok;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ok     = wr_en_i && (!full_o || rd_en_i) && !flush_i;
  assign rd_ok     = rd_en_i && !empty_o && !flush_i;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/adc_fft_framer.sv
// ADC-to-FFT framer: channel select, format conversion and fixed-length AXIS framing.
// Overflow or a mid-frame disable pads the frame with zero beats so the length never breaks.
module adc_fft_framer
  import adc_fft_pkg::*;
#(
  parameter int NPOINT     = 1024,
  parameter int ADC_W      = 8,
  parameter int DOUT_W     = 16,
  parameter int NCH        = 2,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 16,
  localparam int CH_W      = (NCH > 1) ? clog2(NCH) : 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rstn,
  input  logic                  in_valid,
  input  logic [NCH*ADC_W-1:0]  in_data,
  input  logic                  cfg_enable,
  input  logic [CH_W-1:0]       cfg_ch_sel,
  input  logic                  cfg_iq_en,
  input  logic                  cfg_offset_bin,
  input  logic                  cfg_left_just,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [2*DOUT_W-1:0]   m_tdata,
  output logic [1:0]            m_tuser,
  output logic                  ovf_sticky,
  output logic [CNT_W-1:0]      ovf_count,
  output logic [CNT_W-1:0]      frame_count,
  output logic [1:0]            dbg_state_o
);

  localparam int IDX_W = clog2(NPOINT);
  localparam int RAW_W = NCH * ADC_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOINT - 1);

  fsm_state_e          state_q;
  logic [IDX_W-1:0]    idx_q;
  logic                tvalid_q, tlast_q;
  logic [2*DOUT_W-1:0] tdata_q;
  logic [1:0]          tuser_q;
  logic                ovf_sticky_q;
  logic [CNT_W-1:0]    ovf_cnt_q, frame_cnt_q;
  logic [CH_W-1:0]     sh_ch_q;
  logic                sh_iq_q, sh_ofs_q, sh_lj_q;

  logic                fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [RAW_W-1:0]    fifo_rdata;
  logic                hs, can_load, first_beat, in_run, run_stop, run_pad, ovf;
  logic [IDX_W-1:0]    load_idx_d;
  logic [CH_W-1:0]     eff_ch;
  logic                eff_iq, eff_ofs, eff_lj;
  logic [DOUT_W-1:0]   re_word, im_word;
  logic [2*DOUT_W-1:0] load_word_d;

  function automatic logic [ADC_W-1:0] pick(input logic [RAW_W-1:0] raw, input int k);
    logic [ADC_W-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      if (c == k) r = raw[c*ADC_W +: ADC_W];
    end
    return r;
  endfunction

  function automatic logic [DOUT_W-1:0] conv(input logic [ADC_W-1:0] s_in, input logic ofs,
                                             input logic lj);
    logic [ADC_W-1:0]        s;
    logic signed [ADC_W-1:0] ss;
    s            = s_in;
    s[ADC_W-1]   = s_in[ADC_W-1] ^ ofs;
    ss           = $signed(s);
    if (lj) return DOUT_W'(s) << (DOUT_W - ADC_W);
    return DOUT_W'(ss);
  endfunction

  // Raw beats are queued and converted on the way out, so the per-frame config
  // snapshot taken at the index-0 load applies to exactly that frame's beats.
  adc_fft_sync_fifo #(
    .WIDTH (RAW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rstn  (sys_rstn),
    .flush_i   (fifo_flush),
    .wr_en_i   (fifo_push),
    .wr_data_i (in_data),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    hs          = tvalid_q && m_tready;
    can_load    = !tvalid_q || m_tready;
    load_idx_d  = tvalid_q ? idx_q + 1'b1 : idx_q;
    first_beat  = (load_idx_d == '0);
    eff_ch      = first_beat ? cfg_ch_sel     : sh_ch_q;
    eff_iq      = first_beat ? cfg_iq_en      : sh_iq_q;
    eff_ofs     = first_beat ? cfg_offset_bin : sh_ofs_q;
    eff_lj      = first_beat ? cfg_left_just  : sh_lj_q;
    re_word     = conv(pick(fifo_rdata, int'(eff_ch)), eff_ofs, eff_lj);
    im_word     = '0;
    if (eff_iq) im_word = conv(pick(fifo_rdata, (int'(eff_ch) + 1) % NCH), eff_ofs, eff_lj);
    load_word_d = {im_word, re_word};
    in_run      = (state_q == RUN);
    run_stop    = in_run && !cfg_enable && (idx_q == '0) && !tvalid_q;
    run_pad     = in_run && !cfg_enable && !run_stop;
    fifo_pop    = in_run && cfg_enable && can_load && !fifo_empty;
    fifo_push   = in_run && in_valid && (!fifo_full || fifo_pop);
    ovf         = in_run && in_valid && fifo_full && !fifo_pop;
    fifo_flush  = !in_run;
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      tuser_q      <= '0;
      ovf_sticky_q <= 1'b0;
      ovf_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      sh_ch_q      <= '0;
      sh_iq_q      <= 1'b0;
      sh_ofs_q     <= 1'b0;
      sh_lj_q      <= 1'b0;
    end else begin
      if (hs) idx_q <= idx_q + 1'b1;
      if (hs && tlast_q) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (ovf) begin
        ovf_sticky_q <= 1'b1;
        if (ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (cfg_enable) begin
            state_q <= RUN;
            idx_q   <= '0;
          end
        end
        RUN: begin
          if (fifo_pop) begin
            tvalid_q           <= 1'b1;
            tdata_q            <= load_word_d;
            tlast_q            <= (load_idx_d == LAST_IDX);
            tuser_q[TUSER_SOF] <= first_beat;
            tuser_q[TUSER_PAD] <= 1'b0;
            if (first_beat) begin
              sh_ch_q  <= cfg_ch_sel;
              sh_iq_q  <= cfg_iq_en;
              sh_ofs_q <= cfg_offset_bin;
              sh_lj_q  <= cfg_left_just;
            end
          end else if (hs) begin
            tvalid_q <= 1'b0;
          end
          if (ovf || run_pad) state_q <= PAD;
          else if (run_stop)  state_q <= IDLE;
        end
        PAD: begin
          if (hs && tlast_q) begin
            tvalid_q <= 1'b0;
            state_q  <= cfg_enable ? RUN : IDLE;
          end else if (!tvalid_q && (idx_q == '0)) begin
            state_q  <= cfg_enable ? RUN : IDLE;
          end else if (can_load) begin
            tvalid_q           <= 1'b1;
            tdata_q            <= '0;
            tlast_q            <= (load_idx_d == LAST_IDX);
            tuser_q[TUSER_SOF] <= first_beat;
            tuser_q[TUSER_PAD] <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_tvalid    = tvalid_q;
  assign m_tlast     = tlast_q;
  assign m_tdata     = tdata_q;
  assign m_tuser     = tuser_q;
  assign ovf_sticky  = ovf_sticky_q;
  assign ovf_count   = ovf_cnt_q;
  assign frame_count = frame_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adc_fft_framer.sv
// Self-checking bench for adc_fft_framer: scoreboard of expected output beats,
// directed conversion vectors, streaming, overflow padding, disable padding and reset.
module tb_adc_fft_framer;

  localparam int NPOINT     = 16;
  localparam int ADC_W      = 8;
  localparam int DOUT_W     = 16;
  localparam int NCH        = 2;
  localparam int FIFO_DEPTH = 64;
  localparam int CNT_W      = 16;

  // Handshake: a beat transfers on a rising edge where m_tvalid and m_tready are both 1;
  // once valid, data/last/user hold until that edge. in_valid has no backpressure.

  logic                sys_clk = 1'b0;
  logic                sys_rstn;
  logic                in_valid;
  logic [15:0]         in_data;
  logic                cfg_enable, cfg_ch_sel, cfg_iq_en, cfg_offset_bin, cfg_left_just;
  logic                m_tvalid, m_tready, m_tlast;
  logic [31:0]         m_tdata;
  logic [1:0]          m_tuser;
  logic                ovf_sticky;
  logic [CNT_W-1:0]    ovf_count, frame_count;
  logic [1:0]          dbg_state;

  int                  n_checks = 0;
  int                  n_errors = 0;
  logic [34:0]         exp_q[$];
  int                  exp_idx = 0;
  int                  exp_frames = 0;
  logic                f_ch, f_iq, f_ofs, f_lj;
  bit                  mon_en = 1'b0;
  bit                  gap_en = 1'b0;
  bit                  seen_valid = 1'b0;
  int                  gaps = 0;

  always #5 sys_clk = ~sys_clk;

  adc_fft_framer #(
    .NPOINT(NPOINT), .ADC_W(ADC_W), .DOUT_W(DOUT_W), .NCH(NCH),
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn),
    .in_valid(in_valid), .in_data(in_data),
    .cfg_enable(cfg_enable), .cfg_ch_sel(cfg_ch_sel), .cfg_iq_en(cfg_iq_en),
    .cfg_offset_bin(cfg_offset_bin), .cfg_left_just(cfg_left_just),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tuser(m_tuser),
    .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .frame_count(frame_count),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] conv(input logic [7:0] v, input logic ofs, input logic lj);
    logic [7:0] t;
    t = ofs ? (v ^ 8'h80) : v;
    if (lj) return {t, 8'h00};
    return {{8{t[7]}}, t};
  endfunction

  task automatic advance();
    if (exp_idx == NPOINT - 1) begin
      exp_idx = 0;
      exp_frames++;
    end else begin
      exp_idx++;
    end
  endtask

  task automatic push_data(input logic [15:0] d);
    logic [7:0]  re_s, im_s;
    logic [15:0] re, im;
    if (exp_idx == 0) begin
      f_ch = cfg_ch_sel; f_iq = cfg_iq_en; f_ofs = cfg_offset_bin; f_lj = cfg_left_just;
    end
    re_s = f_ch ? d[15:8] : d[7:0];
    im_s = f_ch ? d[7:0]  : d[15:8];
    re   = conv(re_s, f_ofs, f_lj);
    im   = f_iq ? conv(im_s, f_ofs, f_lj) : 16'h0000;
    exp_q.push_back({1'b0, exp_idx == 0, exp_idx == NPOINT - 1, im, re});
    advance();
  endtask

  task automatic push_pad();
    exp_q.push_back({1'b1, exp_idx == 0, exp_idx == NPOINT - 1, 32'h0});
    advance();
  endtask

  task automatic drive(input logic [15:0] d, input bit accepted);
    @(posedge sys_clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    if (accepted) push_data(d);
  endtask

  task automatic send_rand(input int n);
    logic [7:0] lo, hi;
    for (int i = 0; i < n; i++) begin
      lo = 8'($urandom_range(0, 255));
      hi = 8'($urandom_range(0, 255));
      if (hi == lo) hi = ~lo;
      drive({hi, lo}, 1'b1);
    end
  endtask

  task automatic in_idle();
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int c = 0;
    while (exp_q.size() != 0 && c < 300) begin
      @(posedge sys_clk);
      c++;
    end
    check(tag, exp_q.size(), 0);
    repeat (3) @(posedge sys_clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    int c = 0;
    while (dbg_state !== s && c < 50) begin
      @(negedge sys_clk);
      c++;
    end
    check(tag, dbg_state, s);
  endtask

  always @(negedge sys_clk) begin
    if (mon_en && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) check("unexpected_beat", {1'b1, m_tuser, m_tlast, m_tdata}, 0);
      else check("beat", {m_tuser, m_tlast, m_tdata}, exp_q.pop_front());
    end
    if (gap_en) begin
      if (m_tvalid) seen_valid = 1'b1;
      else if (seen_valid) gaps++;
    end
  end

  initial begin
    sys_rstn = 1'b0; in_valid = 1'b0; in_data = '0; m_tready = 1'b1;
    cfg_enable = 1'b0; cfg_ch_sel = 1'b0; cfg_iq_en = 1'b0;
    cfg_offset_bin = 1'b0; cfg_left_just = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_ovf_sticky", ovf_sticky, 0);
    check("rst_ovf_count", ovf_count, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_state", dbg_state, 0);
    @(posedge sys_clk); #1;
    sys_rstn = 1'b1;
    mon_en   = 1'b1;

    // Single channel select, sign extension of 0x80, two-cycle latency.
    cfg_enable = 1'b1; cfg_ch_sel = 1'b1;
    wait_state(2'd1, "enter_run");
    drive(16'h8012, 1'b1);
    in_idle();
    @(negedge sys_clk);
    check("latency_n1_tvalid", m_tvalid, 0);
    @(negedge sys_clk);
    check("latency_n2_tvalid", m_tvalid, 1);
    check("t1_tdata", m_tdata, 32'h0000_FF80);
    check("t1_tuser", m_tuser, 2'b01);
    send_rand(NPOINT - 1);

    // Offset-binary plus left-justify, then an I/Q frame.
    cfg_ch_sel = 1'b0; cfg_offset_bin = 1'b1; cfg_left_just = 1'b1;
    drive(16'h5500, 1'b1);
    send_rand(NPOINT - 1);
    cfg_offset_bin = 1'b0; cfg_left_just = 1'b0; cfg_iq_en = 1'b1;
    drive(16'h017F, 1'b1);
    send_rand(NPOINT - 1);
    in_idle();
    wait_drain("drain_conv");
    check("frames_conv", frame_count, exp_frames);

    // Continuous 64-beat stream: tlast every 16th beat and no bubbles.
    cfg_iq_en = 1'b0;
    gaps = 0; seen_valid = 1'b0; gap_en = 1'b1;
    send_rand(4 * NPOINT);
    in_idle();
    repeat (2) @(negedge sys_clk);
    gap_en = 1'b0;
    wait_drain("drain_stream");
    check("stream_no_gaps", gaps, 0);
    check("frames_stream", frame_count, exp_frames);

    // Overflow: out register holds one beat, FIFO holds FIFO_DEPTH, next beat drops.
    send_rand(3);
    in_idle();
    wait_drain("drain_pre_ovf");
    @(posedge sys_clk); #1;
    m_tready = 1'b0;
    for (int j = 0; j < FIFO_DEPTH + 5; j++) drive(16'($urandom_range(0, 65535)), j == 0);
    in_idle();
    do push_pad(); while (exp_idx != 0);
    @(negedge sys_clk);
    check("ovf_sticky", ovf_sticky, 1);
    check("ovf_count", ovf_count, 1);
    check("ovf_state_pad", dbg_state, 2);
    check("ovf_hold_tvalid", m_tvalid, 1);
    @(posedge sys_clk); #1;
    m_tready = 1'b1;
    wait_drain("drain_pad");
    wait_state(2'd1, "ovf_back_to_run");
    send_rand(NPOINT);
    in_idle();
    wait_drain("drain_after_ovf");
    check("frames_ovf", frame_count, exp_frames);
    check("ovf_count_stable", ovf_count, 1);

    // Disable after five beats: eleven pad beats, then idle.
    send_rand(5);
    in_idle();
    wait_drain("drain_pre_dis");
    @(posedge sys_clk); #1;
    cfg_enable = 1'b0;
    do push_pad(); while (exp_idx != 0);
    wait_drain("drain_dis_pad");
    wait_state(2'd0, "dis_idle");
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      check("idle_tvalid", m_tvalid, 0);
    end
    check("frames_dis", frame_count, exp_frames);

    // Mid-frame channel change only applies from the next frame.
    cfg_enable = 1'b1;
    wait_state(2'd1, "reenable_run");
    send_rand(8);
    cfg_ch_sel = 1'b1;
    send_rand(NPOINT - 8);
    send_rand(NPOINT);
    in_idle();
    wait_drain("drain_chsel");
    check("frames_chsel", frame_count, exp_frames);

    // Asynchronous reset in the middle of a frame.
    send_rand(5);
    @(posedge sys_clk); #1;
    mon_en = 1'b0; sys_rstn = 1'b0; in_valid = 1'b0;
    exp_q.delete(); exp_idx = 0; exp_frames = 0;
    #2;
    check("arst_tvalid", m_tvalid, 0);
    check("arst_tdata", m_tdata, 0);
    check("arst_tuser_tlast", {m_tuser, m_tlast}, 0);
    check("arst_ovf", {ovf_sticky, ovf_count}, 0);
    check("arst_frames", frame_count, 0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rstn = 1'b1; mon_en = 1'b1;
    wait_state(2'd1, "post_rst_run");
    send_rand(NPOINT);
    in_idle();
    wait_drain("drain_post_rst");
    check("frames_post_rst", frame_count, exp_frames);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
